// File: rtl/frame_pkg.sv
// frame_pkg: frame geometry and rectangle-writer state shared with the VGA display path
package frame_pkg;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int FB_ADDR_W = 19;
  localparam int COLOR_W   = 8;
  localparam int FB_SIZE   = H_ACTIVE * V_ACTIVE;
  typedef enum logic [1:0] {IDLE, CLIP, DRAW, DONE} state_t;
endpackage

// File: rtl/fb_rect_writer.sv
// fb_rect_writer: clips a rectangle command to the visible frame and emits one
// frame-buffer write per pixel in raster order
module fb_rect_writer
  import frame_pkg::*;
(
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [9:0]           cmd_x,
  input  logic [8:0]           cmd_y,
  input  logic [9:0]           cmd_w,
  input  logic [8:0]           cmd_h,
  input  logic [COLOR_W-1:0]   cmd_color,
  input  logic                 wr_grant,
  output logic                 wr_en,
  output logic [FB_ADDR_W-1:0] wr_addr,
  output logic [COLOR_W-1:0]   wr_data,
  output logic                 busy,
  output logic                 done
);
  state_t state, state_n;
  logic [9:0] x_r, w_r, col, col_n;
  logic [8:0] y_r, h_r, row, row_n;
  logic [10:0] x_end, y_end, x_end_n, y_end_n, x_sum, y_sum;
  logic [FB_ADDR_W-1:0] line_base, line_base_n, addr_n, y_base, next_base;
  logic [COLOR_W-1:0] color_r, data_n;
  logic ready_n, busy_n, done_n, en_n, accept, degen;
  assign accept    = cmd_valid && cmd_ready;
  assign x_sum     = {1'b0, x_r} + {1'b0, w_r};
  assign y_sum     = {2'b0, y_r} + {2'b0, h_r};
  // y*640 built from shifts so no multiplier is inferred
  assign y_base    = (FB_ADDR_W'(y_r) << 9) + (FB_ADDR_W'(y_r) << 7);
  assign next_base = line_base + FB_ADDR_W'(H_ACTIVE);
  assign degen     = w_r == '0 || h_r == '0 || x_r >= 10'(H_ACTIVE) || y_r >= 9'(V_ACTIVE);
  always_comb begin
    state_n     = state;
    ready_n     = cmd_ready;
    busy_n      = busy;
    done_n      = 1'b0;
    en_n        = wr_en;
    addr_n      = wr_addr;
    data_n      = wr_data;
    col_n       = col;
    row_n       = row;
    line_base_n = line_base;
    x_end_n     = x_end;
    y_end_n     = y_end;
    case (state)
      IDLE: begin
        ready_n = !accept;
        busy_n  = accept;
        state_n = accept ? CLIP : IDLE;
      end
      CLIP: begin
        x_end_n     = x_sum > 11'(H_ACTIVE) ? 11'(H_ACTIVE) : x_sum;
        y_end_n     = y_sum > 11'(V_ACTIVE) ? 11'(V_ACTIVE) : y_sum;
        col_n       = x_r;
        row_n       = y_r;
        line_base_n = y_base;
        addr_n      = y_base + FB_ADDR_W'(x_r);
        data_n      = color_r;
        en_n        = !degen;
        state_n     = degen ? DONE : DRAW;
      end
      DRAW: begin
        if (wr_en && wr_grant) begin
          if ({1'b0, col} < x_end - 11'd1) begin
            col_n  = col + 10'd1;
            addr_n = wr_addr + FB_ADDR_W'(1);
          end else if ({2'b0, row} < y_end - 11'd1) begin
            col_n       = x_r;
            row_n       = row + 9'd1;
            line_base_n = next_base;
            addr_n      = next_base + FB_ADDR_W'(x_r);
          end else begin
            en_n    = 1'b0;
            state_n = DONE;
          end
        end
      end
      default: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        ready_n = 1'b1;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      col       <= '0;
      row       <= '0;
      line_base <= '0;
      x_end     <= '0;
      y_end     <= '0;
      x_r       <= '0;
      y_r       <= '0;
      w_r       <= '0;
      h_r       <= '0;
      color_r   <= '0;
    end else begin
      state     <= state_n;
      cmd_ready <= ready_n;
      busy      <= busy_n;
      done      <= done_n;
      wr_en     <= en_n;
      wr_addr   <= addr_n;
      wr_data   <= data_n;
      col       <= col_n;
      row       <= row_n;
      line_base <= line_base_n;
      x_end     <= x_end_n;
      y_end     <= y_end_n;
      if (state == IDLE && accept) begin
        x_r     <= cmd_x;
        y_r     <= cmd_y;
        w_r     <= cmd_w;
        h_r     <= cmd_h;
        color_r <= cmd_color;
      end
    end
  end
endmodule

// File: tb/tb_fb_rect_writer.sv
// tb_fb_rect_writer: randomized and directed checks of fb_rect_writer against a pixel-list model
`timescale 1ns/1ps
module tb_fb_rect_writer;
  import frame_pkg::*;
  logic clk = 0, i_rst = 0, cmd_valid = 0, wr_grant = 1;
  logic [9:0] cmd_x = 0, cmd_w = 0;
  logic [8:0] cmd_y = 0, cmd_h = 0;
  logic [7:0] cmd_color = 0;
  logic cmd_ready, wr_en, busy, done;
  logic [18:0] wr_addr;
  logic [7:0] wr_data;
  fb_rect_writer dut (.clk(clk), .i_rst(i_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .wr_grant(wr_grant), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  int exp_q[$], obs[$];
  int exp_color, acc_cyc, first_wr, last_wr, done_cyc, n_done = 0, rel = 0;
  bit active = 0, prev_stall = 0, grant_rand = 0, grant_force = 1;
  int prev_addr, prev_data;
  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(posedge clk);
    #1 wr_grant = grant_rand ? ($urandom_range(0, 3) != 0) : grant_force;
  end
  // reference: on each accepted command enqueue every clipped pixel address in raster order
  task automatic model_cmd(input int x, input int y, input int w, input int h);
    int xe, ye;
    xe = (x + w > H_ACTIVE) ? H_ACTIVE : x + w;
    ye = (y + h > V_ACTIVE) ? V_ACTIVE : y + h;
    for (int r = y; r < ye; r++)
      for (int c = x; c < xe; c++)
        exp_q.push_back(r * H_ACTIVE + c);
  endtask
  always @(negedge clk) begin
    if (!i_rst) begin
      exp_q.delete();
      active = 0;
      prev_stall = 0;
      rel = 0;
    end else begin
      rel++;
      if (prev_stall) begin
        chk(wr_en == 1, "stall_hold_en", int'(wr_en), 1);
        chk(int'(wr_addr) == prev_addr, "stall_hold_addr", int'(wr_addr), prev_addr);
        chk(int'(wr_data) == prev_data, "stall_hold_data", int'(wr_data), prev_data);
      end
      if (wr_en) begin
        if (exp_q.size() == 0) chk(0, "spurious_write", int'(wr_addr), -1);
        else begin
          chk(int'(wr_addr) == exp_q[0], "wr_addr", int'(wr_addr), exp_q[0]);
          chk(int'(wr_data) == exp_color, "wr_data", int'(wr_data), exp_color);
          if (wr_grant) void'(exp_q.pop_front());
        end
        chk(int'(wr_addr) < FB_SIZE, "addr_range", int'(wr_addr), FB_SIZE - 1);
        if (wr_grant) begin obs.push_back(int'(wr_addr)); last_wr = cyc; end
        if (first_wr < 0) first_wr = cyc;
      end
      if (done) begin
        chk(exp_q.size() == 0, "done_pixels_left", exp_q.size(), 0);
        chk(active, "done_unexpected", 0, 1);
        active = 0;
        done_cyc = cyc;
        n_done++;
      end
      chk(busy == active, "busy", int'(busy), int'(active));
      if (rel > 1) chk(cmd_ready == !busy, "cmd_ready", int'(cmd_ready), int'(!busy));
      if (cmd_valid && cmd_ready) begin
        model_cmd(cmd_x, cmd_y, cmd_w, cmd_h);
        exp_color = cmd_color;
        active = 1;
        first_wr = -1;
        acc_cyc = cyc + 1;
      end
      prev_stall = wr_en && !wr_grant;
      prev_addr = wr_addr;
      prev_data = wr_data;
    end
  end
  task automatic send(input int x, input int y, input int w, input int h, input int c);
    int n = 0;
    obs.delete();
    @(posedge clk);
    #1 {cmd_x, cmd_y, cmd_w, cmd_h, cmd_color} = {10'(x), 9'(y), 10'(w), 9'(h), 8'(c)};
    cmd_valid = 1;
    forever begin
      @(negedge clk);
      #1;
      if (cmd_ready) break;
      if (++n > 5000) begin chk(0, "accept_timeout", n, 0); break; end
    end
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask
  task automatic wait_done(input int bound);
    int n0 = n_done, n = 0;
    while (n_done == n0) begin
      @(negedge clk);
      #1;
      if (++n > bound) begin chk(0, "done_timeout", n, bound); break; end
    end
  endtask
  initial begin
    int basic[6] = '{1290, 1291, 1292, 1930, 1931, 1932};
    int bad, nd;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk({cmd_ready, busy, done, wr_en} == 4'b0 && wr_addr == 0 && wr_data == 0, "reset_outputs",
          int'({cmd_ready, busy, done, wr_en}), 0);
    end
    @(posedge clk);
    #1 i_rst = 1;
    @(negedge clk);
    chk(cmd_ready == 0, "ready_before_edge", int'(cmd_ready), 0);
    @(negedge clk);
    chk(cmd_ready == 1, "ready_after_release", int'(cmd_ready), 1);
    chk(wr_en == 0, "no_wr_after_reset", int'(wr_en), 0);
    send(10, 2, 3, 2, 8'h05);
    wait_done(100);
    chk(obs.size() == 6, "basic_count", obs.size(), 6);
    foreach (basic[i]) if (i < obs.size()) chk(obs[i] == basic[i], "basic_addr", obs[i], basic[i]);
    chk(first_wr == acc_cyc + 1, "basic_first_wr", first_wr - acc_cyc, 1);
    chk(done_cyc == acc_cyc + 8, "basic_done_time", done_cyc - acc_cyc, 8);
    send(638, 479, 5, 5, 8'h02);
    wait_done(100);
    chk(obs.size() == 2, "clip_count", obs.size(), 2);
    if (obs.size() == 2) begin
      chk(obs[0] == 307198, "clip_addr0", obs[0], 307198);
      chk(obs[1] == 307199, "clip_addr1", obs[1], 307199);
    end
    send(5, 5, 0, 3, 8'h11);
    wait_done(20);
    chk(done_cyc == acc_cyc + 2, "degen_w0_time", done_cyc - acc_cyc, 2);
    chk(obs.size() == 0, "degen_w0_writes", obs.size(), 0);
    send(640, 4, 4, 4, 8'h12);
    wait_done(20);
    chk(done_cyc == acc_cyc + 2, "degen_x640_time", done_cyc - acc_cyc, 2);
    chk(obs.size() == 0, "degen_x640_writes", obs.size(), 0);
    send(3, 480, 4, 4, 8'h13);
    wait_done(20);
    chk(obs.size() == 0, "degen_y480_writes", obs.size(), 0);
    send(0, 0, 640, 3, 8'hA7);
    repeat (100) @(negedge clk);
    grant_force = 0;
    cmd_valid = 1;
    {cmd_x, cmd_y, cmd_w, cmd_h, cmd_color} = {10'd5, 9'd5, 10'd1, 9'd1, 8'h33};
    repeat (3) @(negedge clk);
    grant_force = 1;
    cmd_valid = 0;
    wait_done(5000);
    chk(obs.size() == 1920, "stall_count", obs.size(), 1920);
    bad = 0;
    foreach (obs[i]) if (obs[i] != i) bad++;
    chk(bad == 0, "stall_sequence", bad, 0);
    send(0, 0, 100, 10, 8'h07);
    repeat (40) @(negedge clk);
    nd = n_done;
    @(posedge clk);
    #3 i_rst = 0;
    #1;
    chk({wr_en, busy, cmd_ready, done} == 4'b0 && wr_addr == 0, "async_reset",
        int'({wr_en, busy, cmd_ready, done}), 0);
    repeat (3) @(negedge clk);
    chk(n_done == nd, "no_done_on_reset", n_done - nd, 0);
    @(posedge clk);
    #1 i_rst = 1;
    send(0, 0, 1, 1, 8'h09);
    wait_done(20);
    chk(obs.size() == 1 && obs[0] == 0, "fresh_1x1", obs.size() == 1 ? obs[0] : -1, 0);
    grant_rand = 1;
    for (int k = 0; k < 25; k++) begin
      int x, y, w, h;
      x = (k % 5 == 0) ? $urandom_range(610, 700) : $urandom_range(0, 639);
      y = (k % 5 == 0) ? $urandom_range(460, 511) : $urandom_range(0, 479);
      w = (k % 5 == 0) ? $urandom_range(900, 1023) : $urandom_range(0, 24);
      h = (k % 5 == 0) ? $urandom_range(400, 511) : $urandom_range(0, 24);
      send(x, y, w, h, $urandom_range(0, 255));
      wait_done(20000);
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
